fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side drain stage behind the synchronous FIFO: issues rd_en, captures data_out one cycle later,
//  presents it as a valid/ready stream. 2-entry output buffer sustains 1 word/clk under back-pressure.
//  Never reads an empty FIFO, so the FIFO never raises underflow. Flush command discards all queued data.
// PARAMETERS
//  DATA_WIDTH  16  word width; equals FIFO data width
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           async active-low reset
//  fifo_empty     in   1           FIFO empty flag
//  fifo_data_out  in   DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_en
//  fifo_rd_en     out  1           FIFO read request (combinational)
//  m_valid        out  1           output word valid
//  m_ready        in   1           downstream accept
//  m_data         out  DATA_WIDTH  output word
//  flush          in   1           1-cycle pulse: discard buffered and FIFO contents
//  flush_done     out  1           1-cycle pulse: flush complete
//  busy           out  1           state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, buffer occ=0, inflight=0, m_valid=0, m_data=0, flush_done=0; fifo_rd_en=0
//  while rst_n=0. A reset during FLUSH aborts it with no flush_done.
//  pop = m_valid & m_ready. Buffer is a 2-entry FIFO; m_data = head entry, m_valid = (occ!=0) & state!=FLUSH.
//  inflight = registered fifo_rd_en (0/1); when inflight=1, fifo_data_out is captured this cycle.
//  RUN/IDLE: fifo_rd_en = !fifo_empty & (occ + inflight - pop < 2). Gives 1 word/clk when m_ready=1 steady;
//  occ never exceeds 2; captured words are never dropped.
//  Latency: a word in a non-empty FIFO reaches m_valid 2 clk after fifo_rd_en (rd cycle, capture cycle).
//  Ordering: strict FIFO order; m_data/m_valid held stable while m_valid & !m_ready.
//  Capture and pop in the same cycle: occ unchanged; head advances.
//  States:
//   IDLE : occ=0 & inflight=0. -> RUN when fifo_rd_en asserts. flush -> FLUSH.
//   RUN  : -> IDLE when occ=0, inflight=0 and no rd_en this cycle. flush -> FLUSH (flush has priority over pop).
//   FLUSH: occ cleared on entry; m_valid=0; fifo_rd_en = !fifo_empty (every cycle); captured words discarded.
//          When fifo_empty & inflight=0 -> flush_done=1 for one cycle, -> IDLE.
//  flush while in FLUSH is ignored. flush in IDLE with FIFO empty: FLUSH for 1 cycle, then flush_done.
//  Writes into the FIFO during FLUSH are also drained; flush completes only on an empty FIFO.
// CONFIGURATION
//  FIFO_RD_STREAM_STATS_EN defined: adds outputs stat_words [31:0] (+1 per pop) and stat_stalls [31:0]
//   (+1 per cycle with m_valid & !m_ready). Both saturate at all-ones, reset to 0, and never count in FLUSH.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset with FIFO holding 3 words -> m_valid=0, fifo_rd_en=0, busy=0 while rst_n=0; after release,
//    first m_valid 2 clk after the first fifo_rd_en.
//  2 FIFO preloaded with 0x0001..0x0008, m_ready=1 -> 8 words in order on 8 consecutive cycles;
//    fifo_rd_en never high with fifo_empty=1.
//  3 Same preload, m_ready low 5 cycles then high -> occ stops at 2; fifo_rd_en=0 while stalled;
//    no loss or duplication; m_data stable during stall.
//  4 m_ready toggling 1/0 each cycle on 8 words -> all 8 delivered in order; occ<=2 throughout.
//  5 5 words queued, m_ready=0, flush pulse -> m_valid=0 next cycle; FIFO drained;
//    flush_done exactly once when fifo_empty & inflight=0; then IDLE.
//  6 STATS_EN: 10 pops with 3 stall cycles -> stat_words=10, stat_stalls=3; counters unaffected by a later flush.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream carried out of the FIFO read drain stage.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: issues FIFO reads, buffers up to two words, streams them out, supports flush.
// Optional statistics counters are enabled with the FIFO_RD_STREAM_STATS_EN macro.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   fifo_rd_stream_if.master      m,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]           stat_words,
   output logic [31:0]           stat_stalls
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state;
   logic [1:0]            occ;
   logic                  head;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] obuf [2];
   logic                  pop;

   assign m.m_valid = (occ != 2'd0) && (state != FLUSH);
   assign m.m_data  = obuf[head];
   assign pop       = m.m_valid && m.m_ready;
   assign busy      = (state != IDLE);

   // Reserve a buffer slot for every word already read or being read, so captures are never dropped.
   always_comb begin
      fifo_rd_en = 1'b0;
      if (rst_n) begin
         if (state == FLUSH)
            fifo_rd_en = !fifo_empty;
         else
            fifo_rd_en = !fifo_empty &&
                         (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         occ        <= 2'd0;
         head       <= 1'b0;
         inflight   <= 1'b0;
         flush_done <= 1'b0;
         obuf[0]    <= '0;
         obuf[1]    <= '0;
      end else begin
         inflight   <= fifo_rd_en;
         flush_done <= 1'b0;
         case (state)
            FLUSH: begin
               if (fifo_empty && !inflight) begin
                  flush_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               if (flush) begin
                  // flush wins over a same-cycle pop or capture
                  occ   <= 2'd0;
                  state <= FLUSH;
               end else begin
                  // an outstanding read implies occ <= 1, so the tail is head ^ occ[0]
                  if (inflight)
                     obuf[head ^ occ[0]] <= fifo_data_out;
                  if (pop)
                     head <= ~head;
                  occ <= occ + {1'b0, inflight} - {1'b0, pop};
                  if (state == IDLE) begin
                     if (fifo_rd_en)
                        state <= RUN;
                  end else if ((occ == 2'd0) && !inflight && !fifo_rd_en) begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words  <= 32'd0;
         stat_stalls <= 32'd0;
      end else if (state != FLUSH) begin
         if (pop && (stat_words != 32'hFFFF_FFFF))
            stat_words <= stat_words + 32'd1;
         if (m.m_valid && !m.m_ready && (stat_stalls != 32'hFFFF_FFFF))
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural synchronous FIFO in front of it.
module tb_fifo_rd_stream;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_rd_en;
   logic          flush = 1'b0;
   logic          flush_done;
   logic          busy;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0]   stat_words;
   logic [31:0]   stat_stalls;
`endif

   fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();

   fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_rd_en    (fifo_rd_en),
      .m             (s_if),
      .flush         (flush),
      .flush_done    (flush_done),
      .busy          (busy)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .stat_words    (stat_words),
      .stat_stalls   (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            reads = 0;
   int            pops = 0;
   int            underflows = 0;
   logic          rd_prev = 1'b0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] pend[$];
   logic [DW-1:0] rx[$];

   // FIFO model: one-cycle read latency, writes become visible after the next edge
   always @(posedge clk) begin
      rd_prev <= fifo_rd_en;
      if (fifo_rd_en) begin
         if (q.size() == 0) underflows++;
         else begin
            fifo_data_out <= q.pop_front();
            reads++;
         end
      end
      while (pend.size() > 0) q.push_back(pend.pop_front());
      fifo_empty <= (q.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_words(input int base, input int n);
      for (int i = 0; i < n; i++) pend.push_back(DW'(base + i));
      @(negedge clk);
   endtask

   // mode 0: ready always; 1: ready toggles; 2: ready low for the first 5 cycles
   task automatic run(input int n, input int mode, input int budget, input string tag);
      int            c = 0;
      int            first_c = -1;
      int            last_c = -1;
      int            occ_est;
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      rx.delete();
      while ((rx.size() < n) && (c < budget)) begin
         case (mode)
            0:       s_if.m_ready = 1'b1;
            1:       s_if.m_ready = ((c % 2) == 0);
            default: s_if.m_ready = (c >= 5);
         endcase
         #1;
         occ_est = reads - pops - (rd_prev ? 1 : 0);
         chk({tag, "_rd_on_empty"}, 32'(fifo_rd_en & fifo_empty), 32'd0);
         chk({tag, "_occ_le2"}, 32'(occ_est <= 2), 32'd1);
         if (prev_stall) begin
            chk({tag, "_hold_valid"}, 32'(s_if.m_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(s_if.m_data), 32'(prev_data));
         end
         if ((mode == 2) && (c >= 2) && (c < 5))
            chk({tag, "_stall_rd_en"}, 32'(fifo_rd_en), 32'd0);
         prev_stall = s_if.m_valid && !s_if.m_ready;
         prev_data  = s_if.m_data;
         if (s_if.m_valid && s_if.m_ready) begin
            rx.push_back(s_if.m_data);
            pops++;
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         @(negedge clk);
         c++;
      end
      s_if.m_ready = 1'b0;
      chk({tag, "_count"}, 32'(rx.size()), 32'(n));
      if (mode == 0) chk({tag, "_span"}, 32'(last_c - first_c), 32'(n - 1));
   endtask

   task automatic chk_rx(input string tag, input int base);
      for (int i = 0; i < rx.size(); i++)
         chk({tag, "_word"}, 32'(rx[i]), 32'(base + i));
   endtask

   task automatic wait_flush(input string tag);
      int nd = 0;
      for (int i = 0; i < 30; i++) begin
         chk({tag, "_rd_on_empty"}, 32'(fifo_rd_en & fifo_empty), 32'd0);
         chk({tag, "_mvalid"}, 32'(s_if.m_valid), 32'd0);
         if (flush_done) nd++;
         if (!busy) break;
         @(negedge clk);
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_done_once"}, 32'(nd), 32'd1);
      chk({tag, "_fifo_empty"}, 32'(fifo_empty), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(flush_done), 32'd0);
      pops = reads;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_if.m_ready = 1'b0;

      // reset with three words waiting in the FIFO
      @(negedge clk);
      push_words(32'hA1, 3);
      @(negedge clk);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_mvalid", 32'(s_if.m_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mdata", 32'(s_if.m_data), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("lat_rd_en", 32'(fifo_rd_en), 32'd1);
      chk("lat_mvalid0", 32'(s_if.m_valid), 32'd0);
      @(negedge clk);
      chk("lat_mvalid1", 32'(s_if.m_valid), 32'd0);
      @(negedge clk);
      chk("lat_mvalid2", 32'(s_if.m_valid), 32'd1);
      chk("lat_mdata", 32'(s_if.m_data), 32'h00A1);
      run(3, 0, 20, "t1");
      chk_rx("t1", 32'hA1);
      repeat (2) @(negedge clk);
      chk("t1_idle", 32'(busy), 32'd0);

      // full-rate drain
      push_words(1, 8);
      run(8, 0, 30, "t2");
      chk_rx("t2", 1);

      // back-pressure for five cycles
      push_words(1, 8);
      run(8, 2, 40, "t3");
      chk_rx("t3", 1);

      // ready toggling every cycle
      push_words(1, 8);
      run(8, 1, 40, "t4");
      chk_rx("t4", 1);
      repeat (2) @(negedge clk);

      // flush with two words buffered and three still in the FIFO
      push_words(32'h51, 5);
      repeat (4) @(negedge clk);
      chk("t5_pre_valid", 32'(s_if.m_valid), 32'd1);
      chk("t5_pre_data", 32'(s_if.m_data), 32'h0051);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t5_busy", 32'(busy), 32'd1);
      wait_flush("t5");
      push_words(32'h66, 1);
      run(1, 0, 10, "t5_after");
      chk_rx("t5_after", 32'h66);
      repeat (2) @(negedge clk);

      // flush while idle on an empty FIFO
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("idle_flush_busy", 32'(busy), 32'd1);
      chk("idle_flush_nodone", 32'(flush_done), 32'd0);
      wait_flush("idle_flush");

`ifdef FIFO_RD_STREAM_STATS_EN
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("st_rst_words", stat_words, 32'd0);
      chk("st_rst_stalls", stat_stalls, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      push_words(32'h200, 10);
      run(10, 2, 60, "t6");
      chk_rx("t6", 32'h200);
      chk("st_words", stat_words, 32'd10);
      chk("st_stalls", stat_stalls, 32'd3);
      pend.push_back(16'h0BAD);
      pend.push_back(16'h0BAE);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_flush("t6_flush");
      chk("st_words_after_flush", stat_words, 32'd10);
      chk("st_stalls_after_flush", stat_stalls, 32'd3);
`endif

      chk("no_underflow", 32'(underflows), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
